// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int UART_MAX_REQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first masked request strictly after ptr, wrapping.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Distance from ptr+1 ranks each requester; ptr itself ranks last.
  always_comb begin
    int d;
    int best;
    d       = 0;
    best    = N;
    any     = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - 1 - int'(ptr)) % N;
      if (req[i] && mask[i] && (d < best)) begin
        best    = d;
        any     = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = any && (gnt_idx == IW'(i));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources.
// Optional message locking via req_last when UART_ARB_BURST_EN is defined.
//
// state   | meaning
// IDLE    | waiting for transmitter idle and a request; grants here only
// LOAD    | Tx_Enable pulse, Tx_Byte stable
// BUSY    | frame in flight, waiting for Tx_Done
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           internal_clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
`ifdef UART_ARB_BURST_EN
  input  logic [NUM_REQ-1:0]             req_last,
`endif
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_DATA_W-1:0]         Tx_Byte,
  output logic                           Tx_Enable,
  input  logic                           Tx_Done,
  input  logic                           Tx_Active,
  output logic [ID_W-1:0]                grant_id,
  output logic                           busy
);

  arb_state_e             state, next_state;
  logic [ID_W-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]     lock_mask;
  logic [NUM_REQ-1:0]     pick_gnt;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_any;
  logic [UART_DATA_W-1:0] pick_byte;
  logic                   accept;

`ifdef UART_ARB_BURST_EN
  logic locked;

  always_comb begin
    lock_mask = '1;
    if (locked) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        lock_mask[i] = (grant_id == ID_W'(i));
      end
    end
  end
`else
  assign lock_mask = '1;
`endif

  uart_rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .mask    (lock_mask),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) pick_byte = req_data[i*UART_DATA_W +: UART_DATA_W];
    end
  end

  // Tx_Active gates grants so a frame left running across reset drains first.
  assign accept = (state == ST_IDLE) && !Tx_Active && pick_any;

  always_comb begin
    next_state = state;
    req_ready  = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          req_ready  = pick_gnt;
          next_state = ST_LOAD;
        end
      end
      ST_LOAD: next_state = ST_BUSY;
      ST_BUSY: if (Tx_Done) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign Tx_Enable = (state == ST_LOAD);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge internal_clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      Tx_Byte  <= '0;
      grant_id <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
`ifdef UART_ARB_BURST_EN
      locked   <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (accept) begin
        Tx_Byte  <= pick_byte;
        grant_id <= pick_idx;
        rr_ptr   <= pick_idx;
`ifdef UART_ARB_BURST_EN
        locked   <= ~|(req_last & pick_gnt);
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; burst-lock steps run only with UART_ARB_BURST_EN.
module tb_uart_tx_arbiter;

  logic        internal_clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  Tx_Byte;
  logic        Tx_Enable;
  logic        Tx_Done;
  logic        Tx_Active;
  logic [1:0]  grant_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 internal_clock = ~internal_clock;

  uart_tx_arbiter #(.NUM_REQ(4)) dut (
    .internal_clock (internal_clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
`ifdef UART_ARB_BURST_EN
    .req_last       (req_last),
`endif
    .req_ready      (req_ready),
    .Tx_Byte        (Tx_Byte),
    .Tx_Enable      (Tx_Enable),
    .Tx_Done        (Tx_Done),
    .Tx_Active      (Tx_Active),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge internal_clock);
    #1;
  endtask

  // One full grant: IDLE handshake, LOAD pulse, BUSY, then Tx_Done back to IDLE.
  task automatic do_frame(input string tag, input logic [3:0] exp_ready,
                          input logic [7:0] exp_byte, input logic [1:0] exp_id);
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
    tick;
    chk({tag, "_en"}, 32'(Tx_Enable), 32'd1);
    chk({tag, "_byte"}, 32'(Tx_Byte), 32'(exp_byte));
    chk({tag, "_id"}, 32'(grant_id), 32'(exp_id));
    chk({tag, "_load_ready"}, 32'(req_ready), 32'd0);
    Tx_Active = 1'b1;
    tick;
    chk({tag, "_en_off"}, 32'(Tx_Enable), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    tick;
    tick;
    Tx_Done   = 1'b1;
    Tx_Active = 1'b0;
    tick;
    Tx_Done = 1'b0;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    Tx_Done   = 1'b0;
    Tx_Active = 1'b0;
    tick;
    tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(Tx_Enable), 32'd0);
    chk("rst_byte", 32'(Tx_Byte), 32'd0);
    chk("rst_id", 32'(grant_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    tick;

    // Single requester
    req_valid = 4'b0001;
    req_data  = 32'h0000_0055;
    do_frame("single", 4'b0001, 8'h55, 2'd0);
    req_valid = 4'b0000;
    #1;
    chk("single_noreq", 32'(req_ready), 32'd0);

    // All four valid from reset: 0,1,2,3,0
    reset = 1'b1;
    tick;
    reset     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'hA3A2_A1A0;
    do_frame("rr0", 4'b0001, 8'hA0, 2'd0);
    do_frame("rr1", 4'b0010, 8'hA1, 2'd1);
    do_frame("rr2", 4'b0100, 8'hA2, 2'd2);
    do_frame("rr3", 4'b1000, 8'hA3, 2'd3);
    do_frame("rr4", 4'b0001, 8'hA0, 2'd0);

    // Requesters 1 and 3 only
    req_valid = 4'b0010;
    do_frame("p1", 4'b0010, 8'hA1, 2'd1);
    req_valid = 4'b1010;
    do_frame("p3", 4'b1000, 8'hA3, 2'd3);
    do_frame("p1b", 4'b0010, 8'hA1, 2'd1);
    do_frame("p3b", 4'b1000, 8'hA3, 2'd3);

    // Reset mid-BUSY while the transmitter keeps shifting
    req_valid = 4'b1111;
    tick;
    Tx_Active = 1'b1;
    tick;
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("drain_ready", 32'(req_ready), 32'd0);
      chk("drain_en", 32'(Tx_Enable), 32'd0);
      tick;
    end
    chk("drain_byte", 32'(Tx_Byte), 32'd0);
    Tx_Active = 1'b0;
    do_frame("after_drain", 4'b0001, 8'hA0, 2'd0);

    // Stale Tx_Done in IDLE and in LOAD
    req_valid = 4'b0000;
    Tx_Done   = 1'b1;
    tick;
    Tx_Done = 1'b0;
    chk("stale_idle", 32'(busy), 32'd0);
    req_valid = 4'b0100;
    #1;
    chk("stale_ready", 32'(req_ready), 32'b0100);
    tick;
    chk("stale_load_en", 32'(Tx_Enable), 32'd1);
    Tx_Done   = 1'b1;
    Tx_Active = 1'b1;
    tick;
    Tx_Done = 1'b0;
    chk("stale_load_busy", 32'(busy), 32'd1);
    chk("stale_load_en_off", 32'(Tx_Enable), 32'd0);
    tick;
    tick;
    chk("stale_still_busy", 32'(busy), 32'd1);
    chk("stale_byte", 32'(Tx_Byte), 32'hA2);
    Tx_Done   = 1'b1;
    Tx_Active = 1'b0;
    tick;
    Tx_Done = 1'b0;
    chk("stale_done", 32'(busy), 32'd0);

`ifdef UART_ARB_BURST_EN
    // Requester 2 sends a three-byte message while requester 0 waits
    reset = 1'b1;
    tick;
    reset     = 1'b0;
    req_data  = 32'h0033_00C0;
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    do_frame("burst_b0", 4'b0100, 8'h33, 2'd2);
    req_valid = 4'b0001;
    tick;
    tick;
    chk("burst_wait_ready", 32'(req_ready), 32'd0);
    chk("burst_wait_busy", 32'(busy), 32'd0);
    req_valid = 4'b0101;
    req_data  = 32'h0034_00C0;
    do_frame("burst_b1", 4'b0100, 8'h34, 2'd2);
    req_data  = 32'h0035_00C0;
    req_last  = 4'b0100;
    do_frame("burst_b2", 4'b0100, 8'h35, 2'd2);
    req_last  = 4'b0000;
    do_frame("burst_r0", 4'b0001, 8'hC0, 2'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte sources using round-robin arbitration.
- Accepts bytes on per-requester valid/ready handshakes and drives the transmitter's Tx_Byte/Tx_Enable.
- Sequences exactly one frame per grant, waiting for Tx_Done before re-arbitrating.
- Sits between client logic (command engines, debug ports) and the existing UART transmitter; baud selection stays in the transmitter path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of grant_id.

Ports:
- internal_clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*8  packed bytes; requester i occupies bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept strobe, combinational.
- Tx_Byte  out  8  registered byte to the transmitter.
- Tx_Enable  out  1  one-cycle start pulse to the transmitter.
- Tx_Done  in  1  one-cycle frame-complete pulse from the transmitter.
- Tx_Active  in  1  high while the transmitter is shifting a frame.
- grant_id  out  ID_W  index of the requester owning the current frame.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: Tx_Byte=0, Tx_Enable=0, grant_id=0, busy=0, req_ready=0, rr_ptr=NUM_REQ-1, state=IDLE.
- The transmitter has no reset, so it may still be mid-frame after reset.
- States: IDLE, LOAD, BUSY.
- IDLE:
  - If Tx_Active=1, assert no req_ready and stay in IDLE. This covers post-reset drain.
  - Otherwise, if any req_valid is set, the winner g is the first set bit searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 that cycle (handshake completes on valid&ready).
  - At the clock edge: Tx_Byte<=req_data[g], grant_id<=g, rr_ptr<=g, state<=LOAD.
- LOAD:
  - Tx_Enable=1 for exactly this one cycle; Tx_Byte is stable.
  - Next state is BUSY.
  - A Tx_Done seen in LOAD is stale and is ignored.
- BUSY:
  - Hold Tx_Byte and grant_id; Tx_Enable=0.
  - On Tx_Done=1, go to IDLE.
- Latency:
  - Accept to Tx_Enable is 1 cycle.
  - Tx_Done to the earliest next req_ready is 1 cycle (IDLE cycle).
- req_ready is never asserted outside IDLE; at most one bit is high at any time.
- A requester dropping req_valid before it is granted is legal; no state is kept for it.
- Single requester continuously valid: it is granted every frame.
- All requesters valid from reset: grant order is 0,1,2,3,0,...
- Tx_Done in IDLE is ignored.
- Reset mid-BUSY: the arbiter returns to IDLE and blocks grants until Tx_Active=0; the in-flight byte is not re-sent.

Optional Feature:
- Macro: UART_ARB_BURST_EN.
- With the macro:
  - Adds input port req_last (NUM_REQ bits), sampled with req_data.
  - After a frame whose accepted req_last=0, the next arbitration in IDLE considers only grant_id; other requesters are masked.
  - The lock clears when a byte with req_last=1 is accepted, or on reset.
  - While locked, if the owner's req_valid=0, the arbiter waits in IDLE; it does not time out.
  - This keeps multi-byte messages contiguous on the line.
- Without the macro: no req_last port; every frame re-arbitrates round-robin.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE/LOAD/BUSY);
  - UART_DATA_W=8;
  - max-requester constant.
- Sub-module uart_rr_pick:
  - combinational round-robin picker;
  - inputs: request vector, pointer, optional mask;
  - outputs: one-hot grant, grant index, any-grant flag.

Test Plan:
- Single requester: req_valid=4'b0001, data 0x55 → req_ready[0] for 1 cycle, Tx_Byte=0x55 and Tx_Enable pulse 1 cycle later; after Tx_Done, busy=0 the next cycle.
- All four valid, data 0xA0..0xA3 → Tx_Byte sequence A0,A1,A2,A3,A0; grant_id 0,1,2,3,0; one Tx_Enable per Tx_Done.
- Requesters 1 and 3 valid, last grant=1 → next grant is 3, then 1; requesters 0 and 2 are never acked.
- Reset asserted mid-BUSY while the model holds Tx_Active=1 for 20 more cycles, req_valid=4'b1111 → no req_ready until Tx_Active falls, then grant 0.
- Stale Tx_Done pulse injected in LOAD and in IDLE → no state change; BUSY still waits for the real Tx_Done.
- UART_ARB_BURST_EN: requester 2 sends 3 bytes with last=0,0,1 while requester 0 is valid throughout → bytes from requester 2 are contiguous, then requester 0 is granted.
